// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues PCs to program memory, tags returning words,
// buffers them in a 2-entry in-order queue and hands them to decode via valid/ready.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 32768
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] pc_read_c0,
    input  logic [31:0] instr_reg_c1,
    input  logic        redirect_vld,
    input  logic [31:0] redirect_pc,
    input  logic        dec_ready,
    output logic        instr_vld,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fetch_fault,
    output logic [1:0]  fsm_state_o
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        inflight_v_q, inflight_v_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] head_instr_q, head_instr_d;
    logic [31:0] head_pc_q, head_pc_d;
    logic [31:0] tail_instr_q, tail_instr_d;
    logic [31:0] tail_pc_q, tail_pc_d;
    logic        fault_q, fault_d;

    logic        pc_ok;
    logic        pop;
    logic        push;
    logic [2:0]  occ_after;
    logic        credit_ok;
    logic        issue;
    logic        fault_set;

    // Decode valid/ready: a word is accepted in any cycle where instr_vld and
    // dec_ready are both high; instr/instr_pc stay stable while instr_vld && !dec_ready.
    assign pc_ok     = (pc_q[1:0] == 2'b00) && ({2'b00, pc_q[31:2]} < MEM_WORDS);
    assign pop       = instr_vld & dec_ready;
    assign push      = inflight_v_q & ~redirect_vld;
    assign occ_after = {1'b0, count_q} + {2'b00, inflight_v_q} - {2'b00, pop};
    assign credit_ok = occ_after < 3'd2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:  state_d = ST_RUN;
            ST_RUN:   if (!pc_ok) state_d = ST_FAULT;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_BOOT;
        endcase
        if (redirect_vld) state_d = ST_RUN;
    end

    always_comb begin
        issue     = 1'b0;
        fault_set = 1'b0;
        case (state_q)
            ST_RUN: begin
                issue     = pc_ok & credit_ok & ~redirect_vld;
                fault_set = ~pc_ok & ~redirect_vld;
            end
            default: begin
                issue     = 1'b0;
                fault_set = 1'b0;
            end
        endcase
    end

    always_comb begin
        pc_d          = issue ? pc_q + 32'd4 : pc_q;
        inflight_v_d  = issue;
        inflight_pc_d = issue ? pc_q : inflight_pc_q;
        fault_d       = fault_q | fault_set;
        count_d       = count_q;
        head_instr_d  = head_instr_q;
        head_pc_d     = head_pc_q;
        tail_instr_d  = tail_instr_q;
        tail_pc_d     = tail_pc_q;

        // The returning word always corresponds to the PC issued last cycle.
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_instr_d = instr_reg_c1;
                    head_pc_d    = inflight_pc_q;
                end else begin
                    tail_instr_d = instr_reg_c1;
                    tail_pc_d    = inflight_pc_q;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_instr_d = tail_instr_q;
                head_pc_d    = tail_pc_q;
                count_d      = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_instr_d = instr_reg_c1;
                    head_pc_d    = inflight_pc_q;
                end else begin
                    head_instr_d = tail_instr_q;
                    head_pc_d    = tail_pc_q;
                    tail_instr_d = instr_reg_c1;
                    tail_pc_d    = inflight_pc_q;
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase

        if (redirect_vld) begin
            pc_d         = redirect_pc;
            inflight_v_d = 1'b0;
            fault_d      = 1'b0;
            count_d      = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q          <= RESET_PC;
            inflight_v_q  <= 1'b0;
            inflight_pc_q <= 32'd0;
            count_q       <= 2'd0;
            head_instr_q  <= 32'd0;
            head_pc_q     <= 32'd0;
            tail_instr_q  <= 32'd0;
            tail_pc_q     <= 32'd0;
            fault_q       <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            inflight_v_q  <= inflight_v_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            head_instr_q  <= head_instr_d;
            head_pc_q     <= head_pc_d;
            tail_instr_q  <= tail_instr_d;
            tail_pc_q     <= tail_pc_d;
            fault_q       <= fault_d;
        end
    end

    assign pc_read_c0  = pc_q;
    assign instr_vld   = (count_q != 2'd0);
    assign instr       = head_instr_q;
    assign instr_pc    = head_pc_q;
    assign fetch_fault = fault_q;
    assign fsm_state_o = state_q;

    // The credit rule must keep a return from ever landing on a full queue.
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && !pop && count_q == 2'd2));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized traffic against a
// queue-based reference model of the fetch/return/deliver rules.
module tb_fetch_ctrl;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int unsigned MEM_WORDS = 32768;
    localparam int M_BOOT  = 0;
    localparam int M_RUN   = 1;
    localparam int M_FAULT = 2;

    logic        clk;
    logic        reset_n;
    logic [31:0] pc_read_c0;
    logic [31:0] instr_reg_c1;
    logic        redirect_vld;
    logic [31:0] redirect_pc;
    logic        dec_ready;
    logic        instr_vld;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_fault;
    logic [1:0]  fsm_state_o;

    int checks;
    int errors;
    int step_no;

    // Reference model state.
    logic [63:0] exp_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_ipc;
    bit          m_infl;
    bit          m_fault;
    int          m_st;

    // Words accepted by decode as seen on the DUT pins: {pc, data} and step index.
    logic [63:0] acc_q[$];
    int          acc_t[$];

    fetch_ctrl #(.RESET_PC(RESET_PC), .MEM_WORDS(MEM_WORDS)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pc_read_c0   (pc_read_c0),
        .instr_reg_c1 (instr_reg_c1),
        .redirect_vld (redirect_vld),
        .redirect_pc  (redirect_pc),
        .dec_ready    (dec_ready),
        .instr_vld    (instr_vld),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .fetch_fault  (fetch_fault),
        .fsm_state_o  (fsm_state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000 ^ a;
    endfunction

    always @(posedge clk) instr_reg_c1 <= mem_word(pc_read_c0);

    task automatic model_reset();
        exp_q.delete();
        m_pc    = RESET_PC;
        m_ipc   = 32'd0;
        m_infl  = 1'b0;
        m_fault = 1'b0;
        m_st    = M_BOOT;
    endtask

    task automatic model_step(input bit rdy, input bit rv, input logic [31:0] rpc);
        int occ;
        bit pop;
        bit ok;
        bit issue;
        occ = exp_q.size();
        pop = (occ > 0) && rdy;
        ok  = (m_pc % 4 == 0) && ((m_pc / 4) < MEM_WORDS);
        if (rv) begin
            exp_q.delete();
            m_infl  = 1'b0;
            m_pc    = rpc;
            m_fault = 1'b0;
            m_st    = M_RUN;
        end else begin
            issue = (m_st == M_RUN) && ok && (occ + int'(m_infl) - int'(pop) < 2);
            if (pop) void'(exp_q.pop_front());
            if (m_infl) exp_q.push_back({m_ipc, mem_word(m_ipc)});
            m_infl = issue;
            if (issue) begin
                m_ipc = m_pc;
                m_pc  = m_pc + 32'd4;
            end
            if (m_st == M_BOOT) m_st = M_RUN;
            else if (m_st == M_RUN && !ok) begin
                m_st    = M_FAULT;
                m_fault = 1'b1;
            end
        end
    endtask

    function automatic logic [97:0] model_obs();
        logic [63:0] h;
        if (exp_q.size() == 0) return {1'b0, 64'd0, m_pc, m_fault};
        h = exp_q[0];
        return {1'b1, h[31:0], h[63:32], m_pc, m_fault};
    endfunction

    function automatic logic [97:0] dut_obs();
        if (instr_vld !== 1'b1) return {instr_vld, 64'd0, pc_read_c0, fetch_fault};
        return {1'b1, instr, instr_pc, pc_read_c0, fetch_fault};
    endfunction

    task automatic step(input bit rdy, input bit rv, input logic [31:0] rpc);
        dec_ready    = rdy;
        redirect_vld = rv;
        redirect_pc  = rpc;
        if (instr_vld === 1'b1 && rdy) begin
            acc_q.push_back({instr_pc, instr});
            acc_t.push_back(step_no);
        end
        model_step(rdy, rv, rpc);
        @(posedge clk);
        @(negedge clk);
        step_no++;
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        dec_ready    = 1'b0;
        redirect_vld = 1'b0;
        redirect_pc  = 32'd0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        acc_q.delete();
        acc_t.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        dec_ready = 1'b0;
        redirect_vld = 1'b0;
        redirect_pc = 32'd0;
        #1;
        checks++;
        if ({instr_vld, instr, instr_pc, pc_read_c0, fetch_fault} !== {1'b0, 64'd0, RESET_PC, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got vld=%b instr=%h pc=%h rd=%h flt=%b exp 0/0/0/%h/0",
                     instr_vld, instr, instr_pc, pc_read_c0, fetch_fault, RESET_PC);
        end
        do_reset();
    endtask

    task automatic test_sequential();
        logic [31:0] pcs[$];
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 32'd0);
            pcs.push_back(pc_read_c0);
            checks++;
            if (dut_obs() !== model_obs()) begin
                errors++;
                $display("FAIL seq_model step %0d got %h exp %h", i, dut_obs(), model_obs());
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (pcs[i] !== 32'(4 * i)) begin
                errors++;
                $display("FAIL seq_pc_read idx %0d got %h exp %h", i, pcs[i], 32'(4 * i));
            end
        end
        checks++;
        if (acc_q.size() < 3) begin
            errors++;
            $display("FAIL seq_deliver count got %0d exp >=3", acc_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (acc_q[i] !== {32'(4 * i), mem_word(32'(4 * i))}) begin
                    errors++;
                    $display("FAIL seq_word idx %0d got %h exp %h", i, acc_q[i],
                             {32'(4 * i), mem_word(32'(4 * i))});
                end
            end
            checks++;
            if (acc_t[2] - acc_t[0] !== 2) begin
                errors++;
                $display("FAIL seq_back_to_back got span %0d exp 2", acc_t[2] - acc_t[0]);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 32'd0);
            checks++;
            if ({instr_vld, instr_pc, instr} !== {1'b1, 32'd0, mem_word(32'd0)}) begin
                errors++;
                $display("FAIL stall_hold step %0d got vld=%b pc=%h exp vld=1 pc=0", i, instr_vld, instr_pc);
            end
        end
        checks++;
        if (pc_read_c0 !== 32'd8) begin
            errors++;
            $display("FAIL stall_pc_read got %h exp 00000008", pc_read_c0);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 32'd0);
            checks++;
            if (dut_obs() !== model_obs()) begin
                errors++;
                $display("FAIL stall_model step %0d got %h exp %h", i, dut_obs(), model_obs());
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (acc_q.size() <= i || acc_q[i] !== {32'(4 * i), mem_word(32'(4 * i))}) begin
                errors++;
                $display("FAIL stall_order idx %0d got %h exp pc %h",
                         i, (acc_q.size() > i) ? acc_q[i] : 64'd0, 32'(4 * i));
            end
        end
    endtask

    task automatic test_redirect();
        int b_seen;
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'h100);
        checks++;
        if (instr_vld !== 1'b0) begin
            errors++;
            $display("FAIL redir_flush got vld=%b exp 0", instr_vld);
        end
        step(1'b1, 1'b0, 32'd0);
        checks++;
        if (instr_vld !== 1'b0) begin
            errors++;
            $display("FAIL redir_gap got vld=%b exp 0", instr_vld);
        end
        step(1'b1, 1'b0, 32'd0);
        checks++;
        if ({instr_vld, instr_pc, instr} !== {1'b1, 32'h100, mem_word(32'h100)}) begin
            errors++;
            $display("FAIL redir_first got vld=%b pc=%h instr=%h exp 1/00000100/%h",
                     instr_vld, instr_pc, instr, mem_word(32'h100));
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'd0);
        b_seen = 0;
        foreach (acc_q[i]) if (acc_q[i][63:32] == 32'd4) b_seen++;
        checks++;
        if (b_seen != 0 || acc_q.size() == 0 || acc_q[0][63:32] !== 32'd0) begin
            errors++;
            $display("FAIL redir_drop got b_seen=%0d first=%h exp b_seen=0 first pc 0",
                     b_seen, (acc_q.size() > 0) ? acc_q[0] : 64'd0);
        end
    endtask

    task automatic test_fault_range();
        step(1'b1, 1'b1, 32'h2_0000);
        step(1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'd0);
            checks++;
            if ({fetch_fault, instr_vld, pc_read_c0} !== {1'b1, 1'b0, 32'h2_0000}) begin
                errors++;
                $display("FAIL fault_range step %0d got flt=%b vld=%b rd=%h exp 1/0/00020000",
                         i, fetch_fault, instr_vld, pc_read_c0);
            end
        end
        step(1'b1, 1'b1, 32'h10);
        checks++;
        if (fetch_fault !== 1'b0) begin
            errors++;
            $display("FAIL fault_clear got %b exp 0", fetch_fault);
        end
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        checks++;
        if ({instr_vld, instr_pc, instr} !== {1'b1, 32'h10, mem_word(32'h10)}) begin
            errors++;
            $display("FAIL fault_recover got vld=%b pc=%h instr=%h exp 1/00000010/%h",
                     instr_vld, instr_pc, instr, mem_word(32'h10));
        end
    endtask

    task automatic test_end_of_memory();
        acc_q.delete();
        acc_t.delete();
        step(1'b1, 1'b1, 32'h1_FFF0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 32'd0);
            checks++;
            if (dut_obs() !== model_obs()) begin
                errors++;
                $display("FAIL eom_model step %0d got %h exp %h", i, dut_obs(), model_obs());
            end
        end
        checks++;
        if (acc_q.size() == 0 || acc_q[acc_q.size() - 1] !== {32'h1_FFFC, mem_word(32'h1_FFFC)}) begin
            errors++;
            $display("FAIL eom_last got %h exp pc 0001fffc",
                     (acc_q.size() > 0) ? acc_q[acc_q.size() - 1] : 64'd0);
        end
        checks++;
        if ({fetch_fault, instr_vld, pc_read_c0} !== {1'b1, 1'b0, 32'h2_0000}) begin
            errors++;
            $display("FAIL eom_fault got flt=%b vld=%b rd=%h exp 1/0/00020000",
                     fetch_fault, instr_vld, pc_read_c0);
        end
        step(1'b1, 1'b1, 32'h2);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0);
        checks++;
        if ({fetch_fault, instr_vld, pc_read_c0} !== {1'b1, 1'b0, 32'h2}) begin
            errors++;
            $display("FAIL eom_misaligned got flt=%b vld=%b rd=%h exp 1/0/00000002",
                     fetch_fault, instr_vld, pc_read_c0);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'd0);
        checks++;
        if ({instr_vld, pc_read_c0} !== {1'b1, 32'd8}) begin
            errors++;
            $display("FAIL mid_full got vld=%b rd=%h exp 1/00000008", instr_vld, pc_read_c0);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({instr_vld, pc_read_c0, fetch_fault} !== {1'b0, RESET_PC, 1'b0}) begin
            errors++;
            $display("FAIL mid_async got vld=%b rd=%h flt=%b exp 0/%h/0",
                     instr_vld, pc_read_c0, fetch_fault, RESET_PC);
        end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        acc_q.delete();
        acc_t.delete();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 32'd0);
            checks++;
            if (dut_obs() !== model_obs()) begin
                errors++;
                $display("FAIL mid_model step %0d got %h exp %h", i, dut_obs(), model_obs());
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (acc_q.size() <= i || acc_q[i] !== {32'(4 * i), mem_word(32'(4 * i))}) begin
                errors++;
                $display("FAIL mid_replay idx %0d got %h exp pc %h",
                         i, (acc_q.size() > i) ? acc_q[i] : 64'd0, 32'(4 * i));
            end
        end
    endtask

    task automatic test_random();
        bit          rdy;
        bit          rv;
        logic [31:0] rpc;
        int          sel;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 40) == 0);
            sel = $urandom_range(0, 9);
            if (sel < 6)      rpc = {15'd0, 15'($urandom_range(0, 32767)), 2'b00};
            else if (sel < 8) rpc = 32'h1_FFE0 + {26'd0, 4'($urandom_range(0, 7)), 2'b00};
            else if (sel < 9) rpc = {30'($urandom_range(0, 4096)), 2'($urandom_range(1, 3))};
            else              rpc = $urandom;
            step(rdy, rv, rpc);
            checks++;
            if (dut_obs() !== model_obs()) begin
                errors++;
                $display("FAIL rand_model step %0d got %h exp %h", i, dut_obs(), model_obs());
            end
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        step_no      = 0;
        reset_n      = 1'b0;
        dec_ready    = 1'b0;
        redirect_vld = 1'b0;
        redirect_pc  = 32'd0;
        model_reset();
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_fault_range();
        test_end_of_memory();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
